mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width.
REQ-003 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles; legal range 1..7.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, number of consecutive lost fetch contests before fetch is forced; legal range 1..15.
REQ-005 SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 if_req  in  1  instruction fetch read request.
REQ-009 if_addr  in  ADDR_W  fetch address (pc).
REQ-010 if_gnt  out  1  fetch request accepted this cycle.
REQ-011 if_rvalid  out  1  one-cycle pulse; if_rdata valid.
REQ-012 if_rdata  out  DATA_W  fetch read data.
REQ-013 d_req  in  1  data-port request.
REQ-014 d_we  in  1  1 = write, 0 = read.
REQ-015 d_addr  in  ADDR_W  data address (ALU result).
REQ-016 d_wdata  in  DATA_W  store data.
REQ-017 d_gnt  out  1  data request accepted this cycle.
REQ-018 d_rvalid  out  1  one-cycle pulse; d_rdata valid (reads only).
REQ-019 d_rdata  out  DATA_W  load data.
REQ-020 mem_en, mem_we, mem_addr, mem_wdata  out  1/1/ADDR_W/DATA_W  single-port memory command.
REQ-021 mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after a read command.

Function
REQ-022 States SHALL be IDLE and WAIT; one transaction outstanding at most; no pipelining.
REQ-023 In IDLE with any request, the winner's gnt and mem_en SHALL assert combinationally in that same cycle, with mem_addr/mem_we/mem_wdata driven from the winner (mem_we=0 for fetch).
REQ-024 Priority: data wins over fetch unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-025 starve_cnt SHALL increment on each IDLE cycle where both requests are present and data wins, and SHALL clear whenever fetch is granted; it SHALL saturate at STARVE_LIMIT.
REQ-026 A granted write SHALL complete in the grant cycle; state remains IDLE; no rvalid is produced; the next grant is possible in the following cycle.
REQ-027 A granted read SHALL latch the owner (fetch/data), load lat_cnt = MEM_LAT and move to WAIT.
REQ-028 In WAIT, lat_cnt SHALL decrement each cycle; in the cycle it reaches 1, the owner's rvalid SHALL pulse with rdata = mem_rdata, and the state SHALL return to IDLE.
REQ-029 No gnt SHALL assert while in WAIT or in the response cycle; requesters hold req/addr stable until gnt.
REQ-030 rdata outputs SHALL be zero whenever the corresponding rvalid is low.
REQ-031 Non-winning requests SHALL be neither granted nor dropped; they remain pending at the requester.

Reset
REQ-032 On reset: state=IDLE, lat_cnt=0, starve_cnt=0, owner=fetch; all gnt, rvalid, mem_en, mem_we outputs = 0; all data/address outputs = 0.
REQ-033 Reset during WAIT SHALL discard the outstanding read; no rvalid SHALL be issued for it after reset deassertion.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum (IDLE, WAIT), the owner enum (OWN_IF, OWN_D) and default parameter constants.
REQ-035 Implementation SHALL be a single module with no sub-modules; lat_cnt is 3 bits and starve_cnt is 4 bits.

Verification (MEM_LAT=2, STARVE_LIMIT=3)
REQ-036 Scenario: fetch-only read of 0x100 at cycle 0 -> if_gnt at cycle 0, mem_en=1, mem_addr=0x100; if_rvalid at cycle 2 with the memory word.
REQ-037 Scenario: if_req and d_req read at cycle 0 -> d_gnt at cycle 0; d_rvalid at cycle 2; if_gnt at cycle 3.
REQ-038 Scenario: d_req write of addr 0x40, data 0xDEAD at cycle 0 -> d_gnt=1, mem_we=1 at cycle 0; no d_rvalid; a pending fetch is granted at cycle 1.
REQ-039 Scenario: continuous d_req reads plus continuous if_req -> data wins three contests, the fourth contest goes to fetch, and starve_cnt returns to 0.
REQ-040 Scenario: reset asserted at cycle 1 of a read in WAIT -> all outputs reach 0 asynchronously; no rvalid ever appears for that read.
REQ-041 Scenario: MEM_LAT=1, back-to-back fetch reads -> grant at cycles 0, 2, 4; rvalid at cycles 1, 3, 5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameter values for the memory port arbiter.
package mem_arb_pkg;

    // Controller state: IDLE accepts a new command, WAIT holds one read in flight.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Which requester owns the outstanding read.
    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W       = 64;
    localparam int DEF_DATA_W       = 64;
    localparam int DEF_MEM_LAT      = 2;   // legal 1..7
    localparam int DEF_STARVE_LIMIT = 4;   // legal 1..15

    // Counter widths sized to the legal parameter ranges.
    localparam int LAT_W    = 3;
    localparam int STARVE_W = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a single-port
// memory with fixed read latency. One transaction in flight at a time; data
// has priority, but fetch is forced after STARVE_LIMIT consecutive lost
// contests. Writes complete in the grant cycle, reads park in WAIT until the
// memory word returns.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_LAT      = DEF_MEM_LAT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,

    // Instruction fetch port (read only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    // Data port (read or write)
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    // Single-port memory command / response
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(MEM_LAT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_t              state_q,      state_d;
    owner_t              owner_q,      owner_d;
    logic [LAT_W-1:0]    lat_cnt_q,    lat_cnt_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    logic can_grant;
    logic fetch_wins;
    logic resp_cycle;

    // Arbitration, memory command and response outputs (all combinational).
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;

        // Reset gates the combinational outputs so they drop immediately,
        // not just after the flops clear.
        can_grant  = (state_q == IDLE) && !reset;
        fetch_wins = if_req && (!d_req || (starve_cnt_q == STARVE_MAX));
        resp_cycle = (state_q == WAIT) && (lat_cnt_q == LAT_W'(1)) && !reset;

        if (can_grant) begin
            if (fetch_wins) begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end else if (d_req) begin
                d_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
        end

        if (resp_cycle) begin
            if (owner_q == OWN_IF) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
        end
    end

    // Next-state logic for the FSM, owner, latency and starvation counters.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            IDLE: begin
                // Fairness bookkeeping: a lost contest counts, any fetch grant clears.
                if (if_gnt) begin
                    starve_cnt_d = '0;
                end else if (d_gnt && if_req && (starve_cnt_q != STARVE_MAX)) begin
                    starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                end

                // Reads wait for the memory; writes finish in the grant cycle.
                if (mem_en && !mem_we) begin
                    owner_d   = if_gnt ? OWN_IF : OWN_D;
                    lat_cnt_d = LAT_INIT;
                    state_d   = WAIT;
                end
            end

            WAIT: begin
                if (lat_cnt_q == LAT_W'(1)) begin
                    lat_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                lat_cnt_d = '0;
            end
        endcase
    end

    // State registers; asynchronous reset discards any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule : mem_port_arbiter
